// File: rtl/line_mem_responder.sv
// Shared line-organised backing store for the instruction and data caches.
// Serves one full-line request at a time and answers after a fixed latency.
module line_mem_responder #(
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned MEM_LINES       = 4096,
  parameter int unsigned LATENCY         = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_read_en,
  input  logic                       i_write_en,
  input  logic [31:0]                i_addr,
  input  logic [CACHE_LINE_SIZE-1:0] i_write_data,
  output logic [CACHE_LINE_SIZE-1:0] i_read_data,
  output logic                       i_ready,
  input  logic                       d_read_en,
  input  logic                       d_write_en,
  input  logic [31:0]                d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] d_read_data,
  output logic                       d_ready
);

  localparam int unsigned OFF_W = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam int unsigned CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_LINES];

  logic [1:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       last_is_d_q, last_is_d_d;
  logic                       gnt_is_d_q, gnt_is_d_d;
  logic                       wr_q, wr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CACHE_LINE_SIZE-1:0] line_q, line_d;
  logic                       i_ready_q, i_ready_d;
  logic                       d_ready_q, d_ready_d;
  logic [CACHE_LINE_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [CACHE_LINE_SIZE-1:0] d_rdata_q, d_rdata_d;

  logic                       i_pend_c, d_pend_c, pick_d_c, sel_wr_c;
  logic [IDX_W-1:0]           i_idx_c, d_idx_c, sel_idx_c;
  logic [CACHE_LINE_SIZE-1:0] sel_wdata_c;
  logic                       unused_addr_c;

  // Offset bits and bits above the line index never select a line.
  assign unused_addr_c = ^{i_addr[31:OFF_W+IDX_W], i_addr[OFF_W-1:0],
                           d_addr[31:OFF_W+IDX_W], d_addr[OFF_W-1:0]};

  assign i_idx_c  = i_addr[OFF_W +: IDX_W];
  assign d_idx_c  = d_addr[OFF_W +: IDX_W];
  assign i_pend_c = i_read_en | i_write_en;
  assign d_pend_c = d_read_en | d_write_en;

  // Data wins only when alone or when instruction was served last.
  assign pick_d_c    = d_pend_c & (~i_pend_c | ~last_is_d_q);
  assign sel_wr_c    = pick_d_c ? d_write_en   : i_write_en;
  assign sel_idx_c   = pick_d_c ? d_idx_c      : i_idx_c;
  assign sel_wdata_c = pick_d_c ? d_write_data : i_write_data;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_is_d_d = last_is_d_q;
    gnt_is_d_d  = gnt_is_d_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    line_d      = line_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_pend_c || d_pend_c) begin
          state_d     = S_BUSY;
          cnt_d       = CNT_ONE;
          gnt_is_d_d  = pick_d_c;
          last_is_d_d = pick_d_c;
          wr_d        = sel_wr_c;
          idx_d       = sel_idx_c;
          line_d      = sel_wr_c ? sel_wdata_c : mem_q[sel_idx_c];
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          cnt_d   = '0;
          if (gnt_is_d_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = line_q;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = line_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_is_d_q <= 1'b1;
      gnt_is_d_q  <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      line_q      <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_is_d_q <= last_is_d_d;
      gnt_is_d_q  <= gnt_is_d_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Writes land at the end of the response cycle; reset there aborts them.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_RESP && wr_q) begin
      mem_q[idx_q] <= line_q;
    end
  end

  assign i_ready     = i_ready_q;
  assign d_ready     = d_ready_q;
  assign i_read_data = i_rdata_q;
  assign d_read_data = d_rdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: transaction-level timing model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_line_mem_responder;

  localparam int LAT = 5;
  localparam int LW  = 128;

  logic          clk;
  logic          reset;
  logic          i_read_en, i_write_en, d_read_en, d_write_en;
  logic [31:0]   i_addr, d_addr;
  logic [LW-1:0] i_write_data, d_write_data, i_read_data, d_read_data;
  logic          i_ready, d_ready;

  int n_checks = 0;
  int n_errors = 0;

  line_mem_responder #(.CACHE_LINE_SIZE(LW), .MEM_LINES(4096), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_read_en(i_read_en), .i_write_en(i_write_en), .i_addr(i_addr),
    .i_write_data(i_write_data), .i_read_data(i_read_data), .i_ready(i_ready),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_read_data(d_read_data), .d_ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'({20'd0, a[15:4]});
  endfunction

  // Model: a request granted at edge g shows ready after edge g+LAT-1, its
  // write lands at edge g+LAT, and the next grant can come at edge g+LAT+1.
  bit [LW-1:0] mem_m [4096];
  int          edge_n = 0;
  bit          m_act, m_port_d, m_wr, m_last_d, was_act, pick_d;
  int          m_idx, m_g;
  bit [LW-1:0] m_line;
  bit          exp_ir, exp_dr;
  bit [LW-1:0] exp_ird, exp_drd;

  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      m_act = 1'b0; m_last_d = 1'b1;
      exp_ir = 1'b0; exp_dr = 1'b0; exp_ird = '0; exp_drd = '0;
    end else begin
      was_act = m_act;
      exp_ir = 1'b0; exp_dr = 1'b0;
      if (m_act && edge_n == m_g + LAT - 1) begin
        if (m_port_d) begin exp_dr = 1'b1; exp_drd = m_line; end
        else          begin exp_ir = 1'b1; exp_ird = m_line; end
      end
      if (m_act && edge_n == m_g + LAT) begin
        if (m_wr) mem_m[m_idx] = m_line;
        m_act = 1'b0;
      end
      if (!was_act && (i_read_en || i_write_en || d_read_en || d_write_en)) begin
        pick_d   = (d_read_en || d_write_en) && (!(i_read_en || i_write_en) || !m_last_d);
        m_act    = 1'b1;
        m_g      = edge_n;
        m_port_d = pick_d;
        m_last_d = pick_d;
        m_wr     = pick_d ? d_write_en : i_write_en;
        m_idx    = lidx(pick_d ? d_addr : i_addr);
        m_line   = m_wr ? (pick_d ? d_write_data : i_write_data) : mem_m[m_idx];
      end
    end
    #1;
    chk("i_ready", {127'd0, i_ready}, {127'd0, exp_ir});
    chk("d_ready", {127'd0, d_ready}, {127'd0, exp_dr});
    chk("i_read_data", i_read_data, exp_ird);
    chk("d_read_data", d_read_data, exp_drd);
  end

  // Drives both ports from a negedge and drops each enable on its ready pulse.
  task automatic issue(input bit ir, input bit iw, input logic [31:0] ia, input logic [LW-1:0] iwd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [LW-1:0] dwd,
                       output int ilat, output int dlat,
                       output logic [LW-1:0] idat, output logic [LW-1:0] ddat);
    bit ion, don;
    i_read_en = ir; i_write_en = iw; i_addr = ia; i_write_data = iwd;
    d_read_en = dr; d_write_en = dw; d_addr = da; d_write_data = dwd;
    ion = ir | iw; don = dr | dw;
    ilat = -1; dlat = -1; idat = '0; ddat = '0;
    for (int n = 1; n <= 40 && (ion || don); n++) begin
      @(negedge clk);
      if (ion && i_ready) begin
        ilat = n; idat = i_read_data; i_read_en = 1'b0; i_write_en = 1'b0; ion = 1'b0;
      end
      if (don && d_ready) begin
        dlat = n; ddat = d_read_data; d_read_en = 1'b0; d_write_en = 1'b0; don = 1'b0;
      end
    end
    chk("ready_timeout", {127'd0, ion | don}, '0);
  endtask

  logic [LW-1:0] p1, p2, p3, p4, idt, ddt;
  int il, dl, cnt_i, cnt_d, first_i, first_d, seen;

  initial begin
    p1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    p2 = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;
    p3 = 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
    p4 = 128'hffff_0000_ffff_0000_1234_5678_9abc_def0;
    reset = 1'b0;
    i_read_en = 1'b1; i_write_en = 1'b0; i_addr = 32'h40; i_write_data = '0;
    d_read_en = 1'b1; d_write_en = 1'b0; d_addr = 32'h80; d_write_data = '0;

    // Reset held with both ports requesting.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_i_ready", {127'd0, i_ready}, '0);
      chk("rst_d_ready", {127'd0, d_ready}, '0);
      chk("rst_i_rdata", i_read_data, '0);
      chk("rst_d_rdata", d_read_data, '0);
    end

    // Tie right after reset: instruction first, data six cycles later.
    reset = 1'b1;
    issue(1'b1, 1'b0, 32'h40, '0, 1'b1, 1'b0, 32'h80, '0, il, dl, idt, ddt);
    chk("tie_i_lat", il, 5);
    chk("tie_d_lat", dl, 11);
    chk("tie_i_data", idt, '0);

    // Write then read on the data port.
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h0000_0210, p1, il, dl, idt, ddt);
    chk("wr_lat", dl, 5);
    chk("wr_resp", ddt, p1);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0210, '0, il, dl, idt, ddt);
    chk("rd_lat", dl, 5);
    chk("rd_data", ddt, p1);

    // Address wrap: line 0 seen through address MEM_LINES*16.
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h0000_0000, p2, 1'b0, 1'b0, '0, '0, il, dl, idt, ddt);
    chk("wrap_wr_lat", il, 5);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0001_0000, '0, il, dl, idt, ddt);
    chk("wrap_rd_data", ddt, p2);

    // Read and write together on one port act as a write.
    @(negedge clk);
    issue(1'b1, 1'b1, 32'h0000_0500, p3, 1'b0, 1'b0, '0, '0, il, dl, idt, ddt);
    chk("rw_lat", il, 5);
    chk("rw_resp", idt, p3);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0500, '0, il, dl, idt, ddt);
    chk("rw_readback", ddt, p3);

    // Reset in the second BUSY cycle of a write aborts it.
    @(negedge clk);
    d_write_en = 1'b1; d_addr = 32'h0000_0210; d_write_data = p4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; d_write_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d_ready) seen++;
    end
    chk("abort_no_ready", seen, 0);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0210, '0, il, dl, idt, ddt);
    chk("abort_old_data", ddt, p1);

    // Enable dropped one cycle after being raised still gets its response.
    @(negedge clk);
    d_read_en = 1'b1; d_addr = 32'h0000_0500;
    @(negedge clk);
    d_read_en = 1'b0;
    dl = -1;
    for (int n = 2; n <= 20 && dl < 0; n++) begin
      @(negedge clk);
      if (d_ready) begin dl = n; ddt = d_read_data; end
    end
    chk("drop_lat", dl, 5);
    chk("drop_data", ddt, p3);

    // Sustained contention: ports alternate every LAT+1 cycles.
    @(negedge clk);
    i_read_en = 1'b1; i_addr = 32'h0000_0000;
    d_read_en = 1'b1; d_addr = 32'h0000_0500;
    cnt_i = 0; cnt_d = 0; first_i = -1; first_d = -1;
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      if (i_ready) begin
        cnt_i++; if (first_i < 0) first_i = n;
        chk("cont_i_data", i_read_data, p2);
      end
      if (d_ready) begin
        cnt_d++; if (first_d < 0) first_d = n;
        chk("cont_d_data", d_read_data, p3);
      end
    end
    i_read_en = 1'b0; d_read_en = 1'b0;
    chk("cont_first_i", first_i, 5);
    chk("cont_first_d", first_d, 11);
    chk("cont_cnt_i", cnt_i, 2);
    chk("cont_cnt_d", cnt_d, 2);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Main-memory responder on the cache-line memory interface, serving the instruction cache (fetch stage) and the data cache from one shared line-organised backing store. It accepts full-line read and write requests on two request ports, arbitrates between them, and returns each response after a fixed, parameterised latency with a one-cycle ready pulse. It is the target end of the interface that each cache drives with `out_mem_read_en`, `out_mem_write_en`, `out_mem_addr` and `out_mem_write_data`, and samples through `in_mem_read_data` and `in_mem_ready`.

## Interface
- `CACHE_LINE_SIZE`, 128: line width in bits; must be a multiple of 32.
- `MEM_LINES`, 4096: number of lines in the store; must be a power of two.
- `LATENCY`, 5: cycles from grant to ready pulse; must be ≥ 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_read_en`  in  1  instruction port read request.
- `i_write_en`  in  1  instruction port write request.
- `i_addr`  in  32  instruction port byte address.
- `i_write_data`  in  CACHE_LINE_SIZE  instruction port write line.
- `i_read_data`  out  CACHE_LINE_SIZE  instruction port response line.
- `i_ready`  out  1  instruction port completion pulse.
- `d_read_en`, `d_write_en`, `d_addr`, `d_write_data`, `d_read_data`, `d_ready`: data port; same directions, widths and meanings as the instruction port.

## Operation
- **Line index.** The line index is `addr[log2(CACHE_LINE_SIZE/8) +: log2(MEM_LINES)]`. Offset bits are ignored. Upper bits are ignored, so the address wraps modulo `MEM_LINES`.
- **Pending request.** A port is pending when its `read_en` or `write_en` is high.
- **Read/write on one port.** If both are high on the same port, the operation is a write. The response data is the newly written line.
- **States:**
  - IDLE: no pending port goes to IDLE. One pending port is granted and goes to BUSY. With two pending ports, grant goes to the port not served last.
  - BUSY: the counter runs. When the counter reaches `LATENCY-1`, go to RESP.
  - RESP: one cycle, then go to IDLE.
- **Last-served record.** The last-served register resets to "data", so the instruction port wins the first tie.
- **Grant latch.** On the grant edge, latch port id, operation, line index and write data. Changes to any port's inputs during BUSY or RESP are ignored.
- **RESP cycle.**
  - For the granted port only, `ready` is 1 and `read_data` is the line.
  - A write commits to the store on the RESP edge. A read returns the store contents as of the grant edge.
  - The non-granted port keeps `ready` = 0. Its request stays pending and is evaluated in the next IDLE cycle.
- **Data hold.** `read_data` holds its last response until that port's next RESP. It is valid only while `ready` = 1.
- **Reset.** The store is not cleared by reset. In simulation it initialises to all zeros.

## Timing
- **Reset values.** `i_ready` = `d_ready` = 0, both `read_data` = 0, state IDLE, counter 0.
- **Latency.** A request first seen pending in IDLE cycle T is granted at the end of T. `ready` is high in cycle T+`LATENCY` for exactly one cycle.
- **Back-to-back.** The earliest next grant is the IDLE cycle T+`LATENCY`+1. The cache drops its enable in the cycle after the `ready` pulse, so no request is served twice.
- **Sustained contention.** With both ports requesting continuously, the ports alternate, one response every `LATENCY`+1 cycles.
- **Reset mid-operation.** Reset low during BUSY or RESP aborts the request: no `ready` pulse and no store write. Both outputs return to reset values on that edge.
- **Dropped enable.** A request whose enable drops during BUSY still completes; `ready` pulses anyway.
- **Width rules.** The counter is `$clog2(LATENCY)` bits and never exceeds `LATENCY-1`.

## Test plan
- **Reset values.** Hold `reset`=0 for 3 cycles with both ports requesting -> `i_ready`=`d_ready`=0 and `read_data`=0 throughout.
- **Write then read.**
  - Stimulus: `d_write_en` at `d_addr`=0x0000_0210 with a known line pattern; after its `ready`, `d_read_en` at the same address.
  - Response: each `d_ready` pulses exactly 5 cycles after its grant, and the second `d_read_data` equals the written line.
- **Tie arbitration.** Both ports read in the same IDLE cycle right after reset -> instruction served first, data served next. `d_ready` comes 6 cycles after `i_ready`.
- **Address wrap.** Write at line index 0, then read address `MEM_LINES`×16 (0x0001_0000 with defaults) -> the written line is returned.
- **Read and write on one port.** `i_read_en`=`i_write_en`=1 -> treated as a write, and `i_read_data` equals `i_write_data`.
- **Reset mid-operation.** Assert reset in BUSY cycle 2 of a data write -> no `d_ready` pulse, and a later read at that address returns the old contents.
